// File: rtl/detector_jogada.sv
`default_nettype none
// ============================================================================
// Module   : detector_jogada
// Brief    : Button debouncer with multi-press rejection, one-cycle play pulse
//            and play timeout counter. Optional macro DETECTOR_SINCRONIZADOR_EN
//            adds a two-flop input synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module detector_jogada #(
    parameter int NBOTOES         = 4,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int TIMEOUT_CICLOS  = 250000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NBOTOES-1:0] botoes,
    input  logic               zeraT,
    input  logic               contaT,
    output logic               jogada,
    output logic [NBOTOES-1:0] jogada_valor,
    output logic               timeout,
    output logic [1:0]         db_estado
);

    localparam int c_DEB_W = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam int c_TMR_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;

    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CICLOS - 2);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CICLOS - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        FILTRANDO     = 2'd1,
        VALIDO        = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    logic [NBOTOES-1:0] w_samp;

`ifdef DETECTOR_SINCRONIZADOR_EN
    logic [NBOTOES-1:0] r_sinc1;
    logic [NBOTOES-1:0] r_sinc2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinc1 <= '0;
            r_sinc2 <= '0;
        end else begin
            r_sinc1 <= botoes;
            r_sinc2 <= r_sinc1;
        end
    end

    assign w_samp = r_sinc2;
`else
    assign w_samp = botoes;
`endif

    estado_t            r_estado;
    logic [NBOTOES-1:0] r_captura;
    logic [c_DEB_W-1:0] r_cnt_deb;
    logic               r_jogada;
    logic [NBOTOES-1:0] r_jogada_valor;

    // The pulse register is set on the edge entering VALIDO, so it is high
    // for exactly the cycle the FSM spends in VALIDO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado       <= OCIOSO;
            r_captura      <= '0;
            r_cnt_deb      <= '0;
            r_jogada       <= 1'b0;
            r_jogada_valor <= '0;
        end else begin
            r_jogada <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_samp != '0) begin
                        r_captura <= w_samp;
                        r_cnt_deb <= '0;
                        r_estado  <= FILTRANDO;
                    end
                end
                FILTRANDO: begin
                    if (w_samp != r_captura) begin
                        r_cnt_deb <= '0;
                        r_estado  <= OCIOSO;
                    end else if (r_cnt_deb == c_DEB_LAST) begin
                        if ($onehot(r_captura)) begin
                            r_estado       <= VALIDO;
                            r_jogada       <= 1'b1;
                            r_jogada_valor <= r_captura;
                        end else begin
                            // Multi-button press: silently wait for a full release.
                            r_cnt_deb <= '0;
                            r_estado  <= ESPERA_SOLTAR;
                        end
                    end else begin
                        r_cnt_deb <= r_cnt_deb + c_DEB_ONE;
                    end
                end
                VALIDO: begin
                    r_cnt_deb <= '0;
                    r_estado  <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (w_samp != '0) begin
                        r_cnt_deb <= '0;
                    end else if (r_cnt_deb == c_DEB_LAST) begin
                        r_estado <= OCIOSO;
                    end else begin
                        r_cnt_deb <= r_cnt_deb + c_DEB_ONE;
                    end
                end
                default: begin
                    r_cnt_deb <= '0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    logic [c_TMR_W-1:0] r_cnt_tmr;
    logic               r_timeout;

    // Sticky flag: once set the counter freezes until the next clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt_tmr <= '0;
            r_timeout <= 1'b0;
        end else if (zeraT) begin
            r_cnt_tmr <= '0;
            r_timeout <= 1'b0;
        end else if (contaT && !r_timeout) begin
            if (r_cnt_tmr == c_TMR_LAST) begin
                r_timeout <= 1'b1;
            end else begin
                r_cnt_tmr <= r_cnt_tmr + c_TMR_ONE;
            end
        end
    end

    assign jogada       = r_jogada;
    assign jogada_valor = r_jogada_valor;
    assign timeout      = r_timeout;
    assign db_estado    = r_estado;

endmodule
`default_nettype wire
